// File: rtl/instr_fetch_unit.sv
// Fetch stage between the PC and decode: one outstanding imem read, {pc, instr} FIFO.
// Latency: request the cycle after credit appears; data visible to decode the cycle after rvalid.
// Backpressure: no new request unless the FIFO has room after this cycle's push/pop (credit).
//
// Ports:
//   clk, rst (sync, active-low)        clock and reset
//   pc_addr, flush -> inc_pc           PC interface; flush redirects and discards all work
//   imem_req/addr/gnt/rvalid/rdata     instruction memory req/gnt/rvalid handshake
//   if_valid/if_ready/if_instr/if_pc   FIFO head presented to decode
module instr_fetch_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic              flush,
   output logic              inc_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
   logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
   logic [DATA_W-1:0] instr_mem_q [DEPTH];

   logic              not_empty;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  count_next;
   logic              credit;

   always_comb begin
      not_empty  = (count_q != '0);
      // A flush cancels both FIFO ports for this cycle; the FIFO is simply cleared.
      pop        = not_empty && if_ready && !flush;
      push       = (state_q == S_WAIT) && imem_rvalid && !flush;
      count_next = count_q + CNT_W'(push) - CNT_W'(pop);
      credit     = (count_next < CNT_W'(DEPTH));
   end

   always_comb begin
      state_d   = state_q;
      pend_pc_d = pend_pc_q;
      count_d   = count_next;
      rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;

      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (!flush && credit) state_d = S_REQ;
         end
         S_REQ: begin
            if (imem_gnt) begin
               pend_pc_d = pc_addr;
               // A grant that coincides with a flush still produces data later;
               // it must be swallowed in DROP.
               state_d   = flush ? S_DROP : S_WAIT;
            end else if (flush) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (imem_rvalid)  state_d = (!flush && credit) ? S_REQ : S_IDLE;
            else if (flush)   state_d = S_DROP;
         end
         S_DROP: begin
            // The orphaned response retires the outstanding request even if another
            // flush arrives alongside it; otherwise DROP would wait forever.
            if (imem_rvalid)  state_d = (!flush && credit) ? S_REQ : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are forced to zero while reset is held.
   always_comb begin
      inc_pc    = rst && (flush || ((state_q == S_REQ) && imem_gnt));
      imem_req  = rst && !flush && (state_q == S_REQ);
      imem_addr = rst ? pc_addr : '0;
      if_valid  = rst && not_empty;
      if_instr  = rst ? instr_mem_q[rd_ptr_q] : '0;
      if_pc     = rst ? pc_mem_q[rd_ptr_q]    : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   // Storage needs no reset: entries are only observed behind the count.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         pc_mem_q[wr_ptr_q]    <= pend_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop && (count_q == CNT_W'(DEPTH))));

endmodule
